// File: rtl/rtc_sched_if.sv
// ---------------------------------------------------------------------------
// rtc_sched_if
// Handshake bundle between the RTC transaction scheduler and the 3-wire
// serial engine.
//   eng_start : one-cycle pulse starting one command+data transaction
//   eng_cmd   : RTC command byte (bit0 = 1 means read)
//   eng_wdata : write data byte
//   eng_busy  : engine is mid-transaction
//   eng_done  : one-cycle pulse, transaction finished
//   eng_rdata : read byte, valid in the eng_done cycle
// master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface rtc_sched_if;
  logic       eng_start;
  logic [7:0] eng_cmd;
  logic [7:0] eng_wdata;
  logic       eng_busy;
  logic       eng_done;
  logic [7:0] eng_rdata;

  modport master (
    output eng_start, eng_cmd, eng_wdata,
    input  eng_busy, eng_done, eng_rdata
  );

  modport slave (
    input  eng_start, eng_cmd, eng_wdata,
    output eng_busy, eng_done, eng_rdata
  );
endinterface

// File: rtl/rtc_sched.sv
// ---------------------------------------------------------------------------
// rtc_sched
// Shares the DS1302-style serial engine between a periodic time read
// (seconds, minutes, hours) and a user set-time write. Writes win arbitration
// in IDLE but never preempt a running read. The three time outputs commit
// together after the last read capture.
//
// Parameters
//   POLL_DIV     : clock cycles between poll ticks (>= 2)
// Ports
//   clk, rst     : clock, synchronous active-high reset (shared with engine)
//   eng          : engine handshake (rtc_sched_if.master)
//   set_req_i    : level write request, held until set_ack_o
//   set_sec_i/set_min_i/set_hour_i : BCD values to write
//   set_ack_o    : one-cycle pulse when the write sequence completes
//   sec_o/min_o/hour_o : last committed BCD time
//   time_valid_o : one-cycle pulse when the time outputs update
//   busy_o       : a sequence is in progress
// Build option
//   RTC_SCHED_WP_EN : when defined the write sequence wraps the time writes
//                     in write-protect unlock (0x8E/0x00) and relock
//                     (0x8E/0x80); otherwise only 0x80/0x82/0x84 are written.
// ---------------------------------------------------------------------------
module rtc_sched #(
  parameter int unsigned POLL_DIV = 2500000
) (
  input  logic         clk,
  input  logic         rst,
  rtc_sched_if.master  eng,
  input  logic         set_req_i,
  input  logic [7:0]   set_sec_i,
  input  logic [7:0]   set_min_i,
  input  logic [7:0]   set_hour_i,
  output logic         set_ack_o,
  output logic [7:0]   sec_o,
  output logic [7:0]   min_o,
  output logic [7:0]   hour_o,
  output logic         time_valid_o,
  output logic         busy_o
);

  localparam int unsigned CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

`ifdef RTC_SCHED_WP_EN
  localparam logic [2:0] WR_LAST = 3'd4;
`else
  localparam logic [2:0] WR_LAST = 3'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // {cmd, wdata} for a given sequence step
  function automatic logic [15:0] xfer_sel(input logic wr, input logic [2:0] step,
                                           input logic [7:0] s, input logic [7:0] m,
                                           input logic [7:0] h);
    logic [15:0] x;
    x = 16'h0000;
    if (!wr) begin
      case (step)
        3'd0:    x = 16'h8100;
        3'd1:    x = 16'h8300;
        default: x = 16'h8500;
      endcase
    end else begin
`ifdef RTC_SCHED_WP_EN
      case (step)
        3'd0:    x = 16'h8E00;
        3'd1:    x = {8'h80, s & 8'h7F};
        3'd2:    x = {8'h82, m};
        3'd3:    x = {8'h84, h};
        default: x = 16'h8E80;
      endcase
`else
      case (step)
        3'd0:    x = {8'h80, s & 8'h7F};
        3'd1:    x = {8'h82, m};
        default: x = {8'h84, h};
      endcase
`endif
    end
    return x;
  endfunction

  state_t           state_q;
  logic             mode_wr_q;
  logic [2:0]       step_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       sec_sh_q, min_sh_q;
  logic             eng_start_q;
  logic [7:0]       cmd_q, wdata_q;
  logic [7:0]       sec_q, min_q, hour_q;
  logic             tv_q, ack_q, busy_q;

  logic             tick, last_step, accept, wr_done;
  logic [15:0]      first_x, next_x;

  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    last_step = (step_q == (mode_wr_q ? WR_LAST : 3'd2));
    accept    = (state_q == S_IDLE) && (set_req_i || pend_q);
    wr_done   = (state_q == S_WAIT) && eng.eng_done && last_step && mode_wr_q;
    // Set beats clear: a tick landing on READ entry leaves a pending read,
    // and a finished write forces an immediate readback.
    pend_d = pend_q;
    if (accept && !set_req_i) pend_d = 1'b0;
    if (tick || wr_done)      pend_d = 1'b1;
    first_x = xfer_sel(set_req_i, 3'd0, set_sec_i, set_min_i, set_hour_i);
    next_x  = xfer_sel(mode_wr_q, step_q + 3'd1, set_sec_i, set_min_i, set_hour_i);
  end

  // IDLE and WAIT fire eng_start directly when the engine is free, so a new
  // transaction follows an accept or eng_done with no dead cycle; ISSUE only
  // holds off while the engine still reports busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_wr_q   <= 1'b0;
      step_q      <= 3'd0;
      cnt_q       <= '0;
      pend_q      <= 1'b1;
      sec_sh_q    <= 8'h00;
      min_sh_q    <= 8'h00;
      eng_start_q <= 1'b0;
      cmd_q       <= 8'h00;
      wdata_q     <= 8'h00;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= 8'h00;
      tv_q        <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      eng_start_q <= 1'b0;
      tv_q        <= 1'b0;
      ack_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mode_wr_q        <= set_req_i;
            step_q           <= 3'd0;
            busy_q           <= 1'b1;
            {cmd_q, wdata_q} <= first_x;
            if (!eng.eng_busy) begin
              eng_start_q <= 1'b1;
              state_q     <= S_WAIT;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!eng.eng_busy) begin
            eng_start_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng.eng_done) begin
            if (!mode_wr_q && step_q == 3'd0) sec_sh_q <= eng.eng_rdata & 8'h7F;
            if (!mode_wr_q && step_q == 3'd1) min_sh_q <= eng.eng_rdata & 8'h7F;
            if (last_step) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (mode_wr_q) begin
                ack_q <= 1'b1;
              end else begin
                // 24 h mode: hour keeps only the two BCD digits
                sec_q  <= sec_sh_q;
                min_q  <= min_sh_q;
                hour_q <= eng.eng_rdata & 8'h3F;
                tv_q   <= 1'b1;
              end
            end else begin
              step_q           <= step_q + 3'd1;
              {cmd_q, wdata_q} <= next_x;
              if (!eng.eng_busy) begin
                eng_start_q <= 1'b1;
                state_q     <= S_WAIT;
              end else begin
                state_q <= S_ISSUE;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng.eng_start = eng_start_q;
  assign eng.eng_cmd   = cmd_q;
  assign eng.eng_wdata = wdata_q;
  assign set_ack_o     = ack_q;
  assign sec_o         = sec_q;
  assign min_o         = min_q;
  assign hour_o        = hour_q;
  assign time_valid_o  = tv_q;
  assign busy_o        = busy_q;

endmodule
